// File: rtl/mem_read_pkg.sv
// Shared defaults and constants for the memory read stage.
package mem_read_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 4;

    // Returned in place of SRAM data for rejected (out-of-range) reads.
    localparam logic [15:0] OOB_FILL = 16'hDEAD;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/mem_read_stage_if.sv
// Upstream address, SRAM and downstream data handshake bundle.
// slave = the read stage, master = its surroundings.
interface mem_read_stage_if
    import mem_read_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic [ADDR_W-1:0] addr_in;
    logic              addr_valid;
    logic              addr_ready;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic [15:0]       rd_count;

    modport slave (
        input  addr_in, addr_valid, mem_rdata, data_ready,
        output addr_ready, mem_ren, mem_raddr, data_out, data_valid, rd_count
    );

    modport master (
        output addr_in, addr_valid, mem_rdata, data_ready,
        input  addr_ready, mem_ren, mem_raddr, data_out, data_valid, rd_count
    );
endinterface

// File: rtl/sync_fifo.sv
// Small power-of-two synchronous FIFO used as the read-return buffer.
// Storage is not reset; only pointers and occupancy are.
module sync_fifo
    import mem_read_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointers/occupancy; pointers wrap naturally since DEPTH is 2^AW.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/mem_read_stage.sv
// Memory read stage: issues SRAM reads for accepted addresses and buffers
// the returned data in accept order. Optional feature macro:
// MEM_READ_BOUNDS_EN adds addr_limit/oob_err and replaces out-of-range
// reads with OOB_FILL.
module mem_read_stage
    import mem_read_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_read_stage_if.slave   bus
`ifdef MEM_READ_BOUNDS_EN
    ,input  logic [ADDR_W-1:0] addr_limit
    ,output logic              oob_err
`endif
);
    localparam int CW = cnt_w(DEPTH);

    logic              accept, rd_en, pop;
    logic              inflight_q, inflight_d;
    logic [15:0]       rd_count_q, rd_count_d;
    logic [DATA_W-1:0] push_data, head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;
    logic [CW:0]       credit;

    // A read in flight already owns a buffer slot; a same-cycle pop is
    // deliberately not credited so ready never depends on data_ready.
    assign credit         = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign bus.addr_ready = rst_n && !fifo_full && (credit < (CW+1)'(DEPTH));
    assign accept         = bus.addr_valid && bus.addr_ready;

`ifdef MEM_READ_BOUNDS_EN
    logic oob_acc, oob_q, oob_err_q;

    assign oob_acc   = accept && (bus.addr_in >= addr_limit);
    assign rd_en     = accept && !oob_acc;
    assign push_data = oob_q ? DATA_W'(OOB_FILL) : bus.mem_rdata;
    assign oob_err   = oob_err_q;

    // Track whether the slot in flight is a fill, and latch the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_q     <= 1'b0;
            oob_err_q <= 1'b0;
        end else begin
            oob_q     <= oob_acc;
            oob_err_q <= oob_err_q | oob_acc;
        end
    end
`else
    assign rd_en     = accept;
    assign push_data = bus.mem_rdata;
`endif

    assign bus.mem_ren   = rd_en;
    assign bus.mem_raddr = rd_en ? bus.addr_in : '0;

    assign bus.data_valid = !fifo_empty;
    assign bus.data_out   = fifo_empty ? '0 : head;
    assign bus.rd_count   = rd_count_q;
    assign pop            = bus.data_valid && bus.data_ready;

    // Next-state for in-flight flag and accept counter.
    always_comb begin
        inflight_d = accept;
        rd_count_d = rd_count_q + 16'(accept);
    end

    // Reset clears inflight, so the SRAM return after reset is never pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            rd_count_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            rd_count_q <= rd_count_d;
        end
    end

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   (push_data),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_mem_read_stage.sv
// Directed bench for mem_read_stage with an SRAM model and in-order scoreboard.
// Define MEM_READ_BOUNDS_EN to also exercise the bounds-check build.
module tb_mem_read_stage;
    import mem_read_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_read_stage_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_READ_BOUNDS_EN
    logic [AW-1:0] addr_limit = 16'hFFFF;
    logic          oob_err;
`endif

    mem_read_stage #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MEM_READ_BOUNDS_EN
        ,.addr_limit (addr_limit)
        ,.oob_err    (oob_err)
`endif
    );

    // SRAM content is a fixed function of the address: 0x0010 -> 0x1234.
    function automatic logic [15:0] sram_f(input logic [15:0] a);
        return 16'(a * 16'd3 + 16'h1204);
    endfunction

    // Synchronous SRAM: data one cycle after ren, junk otherwise.
    always @(posedge clk)
        bus.mem_rdata <= bus.mem_ren ? sram_f(bus.mem_raddr) : DW'($urandom);

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_data(input logic [15:0] a);
`ifdef MEM_READ_BOUNDS_EN
        if (a >= addr_limit) return OOB_FILL;
`endif
        return sram_f(a);
    endfunction

    logic [15:0] exp_q[$];
    logic [15:0] nxt_addr = 16'h0055;
    int  acc_tot = 0, acc_sec = 0, pop_sec = 0;
    logic acc_now, pop_now, rdy_now;

    // One clock: sample just after the input change, update model, advance.
    task automatic cycle();
        #1;
        rdy_now = bus.addr_ready;
        acc_now = bus.addr_valid && bus.addr_ready;
        pop_now = bus.data_valid && bus.data_ready;
        if (pop_now) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("sb_data", bus.data_out, exp_q.pop_front());
            pop_sec++;
        end
        if (acc_now) begin
            exp_q.push_back(exp_data(bus.addr_in));
            acc_tot++;
            acc_sec++;
            nxt_addr++;
        end
        @(negedge clk);
        bus.addr_in = nxt_addr;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int drops;
        logic got;
        bus.addr_in    = 16'h0055;
        bus.addr_valid = 1'b1;
        bus.data_ready = 1'b1;

        // Reset values, with a valid address presented.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_addr_ready", bus.addr_ready, 0);
        chk("rst_mem_ren",    bus.mem_ren, 0);
        chk("rst_mem_raddr",  bus.mem_raddr, 0);
        chk("rst_data_valid", bus.data_valid, 0);
        chk("rst_data_out",   bus.data_out, 0);
        chk("rst_rd_count",   bus.rd_count, 0);
        @(negedge clk);

        // Single read: latency 2, data 0x1234.
        rst_n = 1'b1;
        nxt_addr = 16'h0010;
        bus.addr_in = nxt_addr;
        #1;
        chk("t1_ready_after_rst", bus.addr_ready, 1);
        chk("t1_mem_ren",   bus.mem_ren, 1);
        chk("t1_mem_raddr", bus.mem_raddr, 16'h0010);
        cycle();
        bus.addr_valid = 1'b0;
        #1;
        chk("t1_valid_n1",  bus.data_valid, 0);
        chk("t1_raddr_idle", bus.mem_raddr, 0);
        cycle();
        #1;
        chk("t1_valid_n2", bus.data_valid, 1);
        chk("t1_data",     bus.data_out, 16'h1234);
        chk("t1_rd_count", bus.rd_count, 1);
        cycle();

        // 100 back-to-back addresses with data_ready high.
        acc_sec = 0; pop_sec = 0; drops = 0;
        bus.addr_valid = 1'b1;
        for (int i = 0; i < 200 && acc_sec < 100; i++) begin
            cycle();
            if (!rdy_now) drops++;
        end
        bus.addr_valid = 1'b0;
        repeat (4) cycle();
        chk("s_ready_drops", drops, 0);
        chk("s_accepts", acc_sec, 100);
        chk("s_outputs", pop_sec, 100);
        chk("s_rd_count", bus.rd_count, 101);

        // Backpressure: exactly DEPTH accepts, then credit returns a cycle after pop.
        acc_sec = 0;
        bus.data_ready = 1'b0;
        bus.addr_valid = 1'b1;
        repeat (8) cycle();
        chk("bp_accepts", acc_sec, 4);
        #1;
        chk("bp_ready_low", bus.addr_ready, 0);
        bus.data_ready = 1'b1;
        cycle();
        chk("bp_popped", pop_now, 1);
        chk("bp_no_credit_same_cycle", acc_now, 0);
        cycle();
        chk("bp_resume", acc_now, 1);
        bus.addr_valid = 1'b0;
        repeat (6) cycle();
        chk("bp_drained", exp_q.size(), 0);

        // Random valid/ready traffic.
        for (int i = 0; i < 10000; i++) begin
            bus.addr_valid = 1'($urandom_range(0, 1));
            bus.data_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        bus.addr_valid = 1'b0;
        bus.data_ready = 1'b1;
        repeat (8) cycle();
        chk("rnd_empty", exp_q.size(), 0);
        chk("rnd_rd_count", bus.rd_count, acc_tot[15:0]);

        // Reset with 3 buffered entries and one read in flight.
        acc_sec = 0;
        bus.data_ready = 1'b0;
        bus.addr_valid = 1'b1;
        for (int i = 0; i < 10 && acc_sec < 4; i++) cycle();
        chk("mr_setup_accepts", acc_sec, 4);
        rst_n = 1'b0;
        #1;
        chk("mr_addr_ready", bus.addr_ready, 0);
        chk("mr_mem_ren",    bus.mem_ren, 0);
        chk("mr_mem_raddr",  bus.mem_raddr, 0);
        chk("mr_data_valid", bus.data_valid, 0);
        chk("mr_data_out",   bus.data_out, 0);
        chk("mr_rd_count",   bus.rd_count, 0);
        exp_q.delete();
        acc_tot = 0;
        bus.addr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nxt_addr = 16'h0777;
        bus.addr_in = nxt_addr;
        bus.addr_valid = 1'b1;
        bus.data_ready = 1'b1;
        cycle();
        bus.addr_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            #1;
            if (bus.data_valid) begin
                got = 1'b1;
                chk("mr_first_out", bus.data_out, sram_f(16'h0777));
            end
            cycle();
        end
        chk("mr_first_seen", got, 1);
        chk("mr_rd_count_after", bus.rd_count, 1);

`ifdef MEM_READ_BOUNDS_EN
        // Bounds build: in-range read then a fill for the limit address.
        addr_limit = 16'h0100;
        nxt_addr = 16'h00FF;
        bus.addr_in = nxt_addr;
        bus.addr_valid = 1'b1;
        #1;
        chk("b_ren_inrange", bus.mem_ren, 1);
        cycle();
        #1;
        chk("b_ren_oob",   bus.mem_ren, 0);
        chk("b_raddr_oob", bus.mem_raddr, 0);
        cycle();
        bus.addr_valid = 1'b0;
        repeat (4) cycle();
        chk("b_empty",   exp_q.size(), 0);
        chk("b_oob_err", oob_err, 1);
        rst_n = 1'b0;
        #1;
        chk("b_oob_err_rst", oob_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
